// File: rtl/slave_internal_response_rd_arbiter_pkg.sv
// Shared types for the AXI slave read-response arbiter: response codes,
// arbiter FSM states and the requester count.
package axi_slave_package;

    localparam int RD_ARB_N_REQ = 2;

    // AXI RRESP codes widened by one bit so an idle output reads INVALID.
    typedef enum logic [2:0] {
        OKAY    = 3'd0,
        EXOKAY  = 3'd1,
        SLVERR  = 3'd2,
        DECERR  = 3'd3,
        INVALID = 3'd4
    } resp_t;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_ERR,
        GRANT_CPL
    } rd_arb_state_e;

endpackage

// File: rtl/slave_internal_response_rd_arbiter_out_reg.sv
// Registered AXI R output stage: one beat of storage with the
// ~RVALID | RREADY ready term that lets a beat load while one drains.
module axi_r_out_reg
    import axi_slave_package::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ID_WIDTH-1:0]   in_id,
    input  resp_t                 in_resp,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic [ID_WIDTH-1:0]   RID,
    output resp_t                 RRESP,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic                  RLAST
);

    logic                  load;
    logic                  rvalid_q, rvalid_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    resp_t                 rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rlast_q, rlast_d;

    assign in_ready = ~rvalid_q | RREADY;
    assign load     = in_valid & in_ready;

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path leaves it unassigned (no latch).
        rvalid_d = rvalid_q;
        rid_d    = rid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        rlast_d  = rlast_q;
        if (load) begin
            rvalid_d = 1'b1;
            rid_d    = in_id;
            rresp_d  = in_resp;
            rdata_d  = in_data;
            rlast_d  = in_last;
        end else if (RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    // NOTE: the payload flops are reset as well, so RRESP shows INVALID rather than X after reset.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rvalid_q <= 1'b0;
            rid_q    <= '0;
            rresp_q  <= INVALID;
            rdata_q  <= '0;
            rlast_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            rvalid_q <= rvalid_d;
            rid_q    <= rid_d;
            rresp_q  <= rresp_d;
            rdata_q  <= rdata_d;
            rlast_q  <= rlast_d;
        end
    end

    assign RVALID = rvalid_q;
    assign RID    = rid_q;
    assign RRESP  = rresp_q;
    assign RDATA  = rdata_q;
    assign RLAST  = rlast_q;

endmodule

// File: rtl/slave_internal_response_rd_arbiter.sv
// Burst-locked arbiter between the error responder (req 0) and the completion
// path (req 1) onto one registered AXI R stream. Define RD_ARB_ROUND_ROBIN_EN for round-robin ties.
module slave_internal_response_rd_arbiter
    import axi_slave_package::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  err_rvalid,
    output logic                  err_rready,
    input  logic [ID_WIDTH-1:0]   err_rid,
    input  resp_t                 err_rresp,
    input  logic [DATA_WIDTH-1:0] err_rdata,
    input  logic                  err_rlast,
    input  logic                  cpl_rvalid,
    output logic                  cpl_rready,
    input  logic [ID_WIDTH-1:0]   cpl_rid,
    input  resp_t                 cpl_rresp,
    input  logic [DATA_WIDTH-1:0] cpl_rdata,
    input  logic                  cpl_rlast,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic [ID_WIDTH-1:0]   RID,
    output resp_t                 RRESP,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic                  RLAST,
    output logic                  busy
);

    rd_arb_state_e               state_q, state_d;
    logic [RD_ARB_N_REQ-1:0]     req;
    logic                        win_cpl;
    logic                        sel_cpl;
    logic                        in_valid;
    logic                        out_ready;
    logic [ID_WIDTH-1:0]         in_id;
    resp_t                       in_resp;
    logic [DATA_WIDTH-1:0]       in_data;
    logic                        in_last;

`ifdef RD_ARB_ROUND_ROBIN_EN
    logic last_gnt_q, last_gnt_d;   // 0 = err, 1 = cpl
`endif

    assign req = {cpl_rvalid, err_rvalid};

    always_comb begin
        state_d    = state_q;
        win_cpl    = 1'b0;
        sel_cpl    = 1'b0;
        in_valid   = 1'b0;
        err_rready = 1'b0;
        cpl_rready = 1'b0;
`ifdef RD_ARB_ROUND_ROBIN_EN
        last_gnt_d = last_gnt_q;
`endif
        case (state_q)
            IDLE: begin
                // Decision cycle only: the granted source's first beat is taken next cycle.
                if (req != '0) begin
`ifdef RD_ARB_ROUND_ROBIN_EN
                    win_cpl    = (&req) ? ~last_gnt_q : req[1];
                    last_gnt_d = win_cpl;
`else
                    win_cpl    = ~req[0];
`endif
                    state_d = win_cpl ? GRANT_CPL : GRANT_ERR;
                end
            end
            GRANT_ERR: begin
                err_rready = out_ready;
                in_valid   = err_rvalid;
                if (err_rvalid && out_ready && err_rlast) begin
                    state_d = IDLE;
                end
            end
            GRANT_CPL: begin
                sel_cpl    = 1'b1;
                cpl_rready = out_ready;
                in_valid   = cpl_rvalid;
                if (cpl_rvalid && out_ready && cpl_rlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_id   = sel_cpl ? cpl_rid   : err_rid;
    assign in_resp = sel_cpl ? cpl_rresp : err_rresp;
    assign in_data = sel_cpl ? cpl_rdata : err_rdata;
    assign in_last = sel_cpl ? cpl_rlast : err_rlast;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef RD_ARB_ROUND_ROBIN_EN
    // Reset to cpl so the first tie goes to the error responder.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`endif

    axi_r_out_reg #(
        .ID_WIDTH   (ID_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .in_valid (in_valid),
        .in_ready (out_ready),
        .in_id    (in_id),
        .in_resp  (in_resp),
        .in_data  (in_data),
        .in_last  (in_last),
        .RVALID   (RVALID),
        .RREADY   (RREADY),
        .RID      (RID),
        .RRESP    (RRESP),
        .RDATA    (RDATA),
        .RLAST    (RLAST)
    );

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_slave_internal_response_rd_arbiter.sv
// Randomized bench for slave_internal_response_rd_arbiter with a transaction-level
// model; honours RD_ARB_ROUND_ROBIN_EN for the tie-break expectation.
`timescale 1ns/1ps
module tb_slave_internal_response_rd_arbiter;
    import axi_slave_package::*;

    localparam int IW = 4;
    localparam int DW = 64;
`ifdef RD_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          ACLK = 1'b0;
    logic          ARESETn;
    logic          err_rvalid, err_rready, err_rlast;
    logic [IW-1:0] err_rid;
    resp_t         err_rresp;
    logic [DW-1:0] err_rdata;
    logic          cpl_rvalid, cpl_rready, cpl_rlast;
    logic [IW-1:0] cpl_rid;
    resp_t         cpl_rresp;
    logic [DW-1:0] cpl_rdata;
    logic          RVALID, RREADY, RLAST, busy;
    logic [IW-1:0] RID;
    resp_t         RRESP;
    logic [DW-1:0] RDATA;

    always #5 ACLK = ~ACLK;

    slave_internal_response_rd_arbiter #(.ID_WIDTH(IW), .DATA_WIDTH(DW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .err_rvalid(err_rvalid), .err_rready(err_rready), .err_rid(err_rid),
        .err_rresp(err_rresp), .err_rdata(err_rdata), .err_rlast(err_rlast),
        .cpl_rvalid(cpl_rvalid), .cpl_rready(cpl_rready), .cpl_rid(cpl_rid),
        .cpl_rresp(cpl_rresp), .cpl_rdata(cpl_rdata), .cpl_rlast(cpl_rlast),
        .RVALID(RVALID), .RREADY(RREADY), .RID(RID), .RRESP(RRESP),
        .RDATA(RDATA), .RLAST(RLAST), .busy(busy)
    );

    typedef struct {
        logic [IW-1:0] id;
        resp_t         resp;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;
    typedef struct {
        int            len;
        logic [IW-1:0] id;
        resp_t         resp;
        int            seq;
    } burst_t;
    typedef struct {
        beat_t b;
        int    cyc;
    } obs_t;

    // Stimulus: per-requester burst queues, beat cursor and AXI valid-hold flag.
    burst_t bq[2][$];
    int     beat_i[2];
    bit     hold[2];
    int     vpct[2];
    int     nseq[2];
    bit     vld[2];
    beat_t  cur[2];
    int     rready_pct;
    int     stall_cnt;

    // Model: who owns the channel (-1 = nobody), who wins the next tie, output beat.
    int     owner;
    int     tie_next;
    bit     out_v;
    beat_t  out_b;
    obs_t   out_log[$];
    int     cyc_n;

    int     n_chk;
    int     n_pass;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Beat payload: source in [63:56], burst sequence in [55:32], beat index in [31:0].
    function automatic beat_t beat_of(input int s);
        beat_t b;
        b.id   = bq[s][0].id;
        b.resp = bq[s][0].resp;
        b.data = {8'(s), 24'(bq[s][0].seq), 32'(beat_i[s])};
        b.last = (beat_i[s] == bq[s][0].len - 1);
        return b;
    endfunction

    function automatic logic [63:0] pk(input int src, input int beat, input logic last, input logic [IW-1:0] id);
        return {16'(src), 32'(beat), 8'(last), 8'(id)};
    endfunction

    task automatic push(input int s, input int len, input logic [IW-1:0] id, input resp_t resp);
        burst_t b;
        b.len  = len;
        b.id   = id;
        b.resp = resp;
        b.seq  = nseq[s];
        nseq[s]++;
        bq[s].push_back(b);
    endtask

    task automatic drive();
        for (int s = 0; s < 2; s++) begin
            if (bq[s].size() > 0) begin
                cur[s] = beat_of(s);
                if (!hold[s]) vld[s] = ($urandom_range(0, 99) < vpct[s]);
            end else begin
                vld[s] = 1'b0;
            end
            hold[s] = vld[s];
        end
        err_rvalid = vld[0]; err_rid = cur[0].id; err_rresp = cur[0].resp;
        err_rdata  = cur[0].data; err_rlast = cur[0].last;
        cpl_rvalid = vld[1]; cpl_rid = cur[1].id; cpl_rresp = cur[1].resp;
        cpl_rdata  = cur[1].data; cpl_rlast = cur[1].last;
        if (stall_cnt > 0) begin
            RREADY = 1'b0;
            stall_cnt--;
        end else begin
            RREADY = ($urandom_range(0, 99) < rready_pct);
        end
    endtask

    task automatic compare();
        bit rdy0, rdy1;
        rdy0 = (owner == 0) && (!out_v || RREADY);
        rdy1 = (owner == 1) && (!out_v || RREADY);
        check("err_rready", 64'(err_rready), 64'(rdy0));
        check("cpl_rready", 64'(cpl_rready), 64'(rdy1));
        check("RVALID", 64'(RVALID), 64'(out_v));
        check("busy", 64'(busy), 64'(owner != -1));
        check("RID", 64'(RID), 64'(out_b.id));
        check("RRESP", 64'(RRESP), 64'(out_b.resp));
        check("RDATA", RDATA, out_b.data);
        check("RLAST", 64'(RLAST), 64'(out_b.last));
    endtask

    task automatic advance();
        bit acc;
        int old;
        obs_t o;
        if (out_v && RREADY) begin
            o.b = out_b;
            o.cyc = cyc_n;
            out_log.push_back(o);
        end
        old = owner;
        acc = 1'b0;
        for (int s = 0; s < 2; s++) begin
            if (owner == s && (!out_v || RREADY) && vld[s]) begin
                acc     = 1'b1;
                out_b   = cur[s];
                hold[s] = 1'b0;
                if (cur[s].last) begin
                    void'(bq[s].pop_front());
                    beat_i[s] = 0;
                    owner = -1;
                end else begin
                    beat_i[s]++;
                end
            end
        end
        if (acc) out_v = 1'b1;
        else if (RREADY) out_v = 1'b0;
        if (old == -1 && (vld[0] || vld[1])) begin
            if (vld[0] && vld[1]) owner = RR ? tie_next : 0;
            else owner = vld[1] ? 1 : 0;
            tie_next = 1 - owner;
        end
        cyc_n++;
    endtask

    task automatic cyc();
        drive();
        #1;
        compare();
        advance();
        @(negedge ACLK);
    endtask

    task automatic model_reset();
        owner = -1;
        tie_next = 0;
        out_v = 1'b0;
        out_b.id = '0; out_b.resp = INVALID; out_b.data = '0; out_b.last = 1'b0;
        for (int s = 0; s < 2; s++) begin
            bq[s].delete();
            beat_i[s] = 0;
            hold[s] = 1'b0;
            vld[s] = 1'b0;
            cur[s] = out_b;
        end
        err_rvalid = 1'b0; err_rid = '0; err_rresp = OKAY; err_rdata = '0; err_rlast = 1'b0;
        cpl_rvalid = 1'b0; cpl_rid = '0; cpl_rresp = OKAY; cpl_rdata = '0; cpl_rlast = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_RVALID"}, 64'(RVALID), 64'(0));
        check({tag, "_RLAST"}, 64'(RLAST), 64'(0));
        check({tag, "_RID"}, 64'(RID), 64'(0));
        check({tag, "_RRESP"}, 64'(RRESP), 64'(INVALID));
        check({tag, "_RDATA"}, RDATA, 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_err_rready"}, 64'(err_rready), 64'(0));
        check({tag, "_cpl_rready"}, 64'(cpl_rready), 64'(0));
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((bq[0].size() > 0 || bq[1].size() > 0 || out_v || owner != -1) && n < max) begin
            cyc();
            n++;
        end
        check("drain_in_budget", 64'(n < max), 64'(1));
    endtask

    task automatic check_log(input string tag, input int idx, input int src, input int beat,
                             input logic last, input logic [IW-1:0] id);
        if (idx >= out_log.size()) begin
            check({tag, "_missing"}, 64'(out_log.size()), 64'(idx + 1));
        end else begin
            check(tag, pk(int'(out_log[idx].b.data[63:56]), int'(out_log[idx].b.data[31:0]),
                          out_log[idx].b.last, out_log[idx].b.id), pk(src, beat, last, id));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int total;
        int bad;
        n_chk = 0; n_pass = 0; cyc_n = 0;
        nseq[0] = 0; nseq[1] = 0;
        vpct[0] = 100; vpct[1] = 100;
        rready_pct = 100; stall_cnt = 0;
        RREADY = 1'b0;
        model_reset();
        ARESETn = 1'b1;
        #1 ARESETn = 1'b0;
        #2 check_reset_outputs("por");
        @(negedge ACLK);
        @(negedge ACLK);
        ARESETn = 1'b1;

        // Single error read: grant in cycle 0, accept in cycle 1, RVALID in cycle 2.
        push(0, 1, 4'd3, SLVERR);
        cyc(); cyc();
        check("single_RVALID", 64'(RVALID), 64'(1));
        check("single_RID", 64'(RID), 64'(3));
        check("single_RRESP", 64'(RRESP), 64'(SLVERR));
        check("single_RLAST", 64'(RLAST), 64'(1));
        cyc();
        check("single_idle_busy", 64'(busy), 64'(0));
        check("single_idle_RVALID", 64'(RVALID), 64'(0));
        out_log.delete();

        // Burst lock: err arrives mid cpl burst and must wait for RLAST.
        push(1, 4, 4'd5, OKAY);
        cyc(); cyc(); cyc();
        push(0, 1, 4'd2, DECERR);
        drain(100);
        for (int i = 0; i < 4; i++) check_log("lock_cpl", i, 1, i, (i == 3), 4'd5);
        check_log("lock_err", 4, 0, 0, 1'b1, 4'd2);
        if (out_log.size() == 5) check("lock_gap", 64'(out_log[4].cyc - out_log[3].cyc), 64'(2));
        else check("lock_count", 64'(out_log.size()), 64'(5));
        out_log.delete();

        // Backpressure: three stalled cycles while beat 1 is on the output.
        push(1, 4, 4'd6, OKAY);
        cyc(); cyc(); cyc();
        stall_cnt = 3;
        cyc(); cyc(); cyc();
        check("bp_RVALID", 64'(RVALID), 64'(1));
        check("bp_RDATA_held", 64'(RDATA[31:0]), 64'(1));
        drain(100);
        check("bp_count", 64'(out_log.size()), 64'(4));
        for (int i = 0; i < 4; i++) check_log("bp_beat", i, 1, i, (i == 3), 4'd6);
        out_log.delete();

        // Ties: last grant so far went to cpl, so round-robin starts with err.
        for (int i = 0; i < 4; i++) begin
            push(0, 1, 4'd1, SLVERR);
            push(1, 1, 4'd8, OKAY);
        end
        drain(200);
        for (int i = 0; i < 4; i++) check_log("tie", i, RR ? (i % 2) : 0, 0, 1'b1, RR ? ((i % 2) ? 4'd8 : 4'd1) : 4'd1);
        check("tie_count", 64'(out_log.size()), 64'(8));
        out_log.delete();

        // Throughput: 8 consecutive output beats, RLAST only on the last.
        push(1, 8, 4'd7, EXOKAY);
        drain(100);
        check("tput_count", 64'(out_log.size()), 64'(8));
        for (int i = 0; i < 8 && i < out_log.size(); i++) begin
            check_log("tput_beat", i, 1, i, (i == 7), 4'd7);
            check("tput_cycle", 64'(out_log[i].cyc - out_log[0].cyc), 64'(i));
        end
        out_log.delete();

        // Reset while beat 2 of 4 is offered.
        push(1, 4, 4'd9, OKAY);
        cyc(); cyc(); cyc();
        drive();
        #2 ARESETn = 1'b0;
        #1 check_reset_outputs("midrst");
        model_reset();
        @(negedge ACLK);
        ARESETn = 1'b1;
        out_log.delete();
        push(0, 2, 4'd4, DECERR);
        drain(100);
        check("postrst_count", 64'(out_log.size()), 64'(2));
        check_log("postrst_beat0", 0, 0, 0, 1'b0, 4'd4);
        check_log("postrst_beat1", 1, 0, 1, 1'b1, 4'd4);
        out_log.delete();

        // Randomized bursts, valid gaps and backpressure.
        rready_pct = 70;
        total = 0;
        for (int k = 0; k < 30; k++) begin
            for (int s = 0; s < 2; s++) begin
                int len;
                len = $urandom_range(1, 8);
                total += len;
                push(s, len, 4'($urandom_range(0, 15)), resp_t'(3'($urandom_range(0, 3))));
            end
            if (k % 10 == 0) begin
                vpct[0] = $urandom_range(40, 100);
                vpct[1] = $urandom_range(40, 100);
            end
        end
        drain(5000);
        check("rand_beats", 64'(out_log.size()), 64'(total));
        bad = 0;
        for (int i = 1; i < out_log.size(); i++) begin
            if (!out_log[i-1].b.last) begin
                if (out_log[i].b.data[63:32] != out_log[i-1].b.data[63:32] ||
                    out_log[i].b.data[31:0] != out_log[i-1].b.data[31:0] + 32'd1) bad++;
            end else if (out_log[i].b.data[31:0] != 32'd0) begin
                bad++;
            end
        end
        check("rand_contiguous", 64'(bad), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
